aes_dec_round_ctrl: RTL and testbench

//  Iterative AES-128 decryption sequencer. Owns the 128-bit state register, the

---
 rtl/aes_dec_round_ctrl.sv | 118 +++++++++++
 tb/tb_aes_dec_round_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_dec_round_ctrl.sv
// Iterative AES-128 decryption sequencer: owns the state register, round counter
// and round-key index, and drives one shared external inverse-round datapath.
module aes_dec_round_ctrl #(
    parameter int NR  = 10,
    parameter int KAW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    output logic [KAW-1:0]   key_addr,
    input  logic [127:0]     key_data,
    output logic [127:0]     dp_state,
    output logic [127:0]     dp_key,
    output logic             dp_first,
    input  logic [127:0]     dp_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic             busy,
    output logic [KAW-1:0]   rnd
);

    localparam logic [KAW-1:0] LP_NR  = KAW'(NR);
    localparam logic [KAW-1:0] LP_ONE = KAW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    state_t           r_fsm;
    state_t           w_fsm_nxt;
    logic [127:0]     r_state;
    logic [127:0]     w_state_nxt;
    logic [127:0]     r_out_data;
    logic [127:0]     w_out_data_nxt;
    logic [KAW-1:0]   r_key_addr;
    logic [KAW-1:0]   w_key_addr_nxt;
    logic [KAW-1:0]   r_rnd;
    logic [KAW-1:0]   w_rnd_nxt;
    logic             r_out_valid;
    logic             w_out_valid_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= S_IDLE;
            r_state     <= '0;
            r_out_data  <= '0;
            r_key_addr  <= '0;
            r_rnd       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_fsm       <= w_fsm_nxt;
            r_state     <= w_state_nxt;
            r_out_data  <= w_out_data_nxt;
            r_key_addr  <= w_key_addr_nxt;
            r_rnd       <= w_rnd_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt       = r_fsm;
        w_state_nxt     = r_state;
        w_out_data_nxt  = r_out_data;
        w_key_addr_nxt  = r_key_addr;
        w_rnd_nxt       = r_rnd;
        w_out_valid_nxt = r_out_valid;
        case (r_fsm)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt    = in_data;
                    w_key_addr_nxt = LP_NR;
                    w_rnd_nxt      = LP_NR;
                    w_fsm_nxt      = S_ROUND;
                end
            end
            S_ROUND: begin
                // key_addr steps with rnd so key[r-1] is presented in the following cycle
                w_state_nxt    = dp_result;
                w_key_addr_nxt = r_rnd - LP_ONE;
                w_rnd_nxt      = r_rnd - LP_ONE;
                if (r_rnd == LP_ONE) begin
                    w_fsm_nxt = S_FINAL;
                end
            end
            S_FINAL: begin
                w_out_data_nxt  = r_state ^ key_data;
                w_out_valid_nxt = 1'b1;
                w_fsm_nxt       = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_fsm_nxt       = S_IDLE;
                end
            end
            default: begin
                w_fsm_nxt = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (r_fsm == S_IDLE);
    assign busy      = (r_fsm != S_IDLE);
    assign key_addr  = r_key_addr;
    assign rnd       = r_rnd;
    assign dp_state  = r_state;
    assign dp_key    = key_data;
    assign dp_first  = (r_fsm == S_ROUND) && (r_rnd == LP_NR);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Bench for aes_dec_round_ctrl: AES inverse-round datapath and key-store models
// around the DUT; expected plaintexts come from a forward AES-128 encryption model.
module tb_aes_dec_round_ctrl;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   key_addr;
    logic [127:0] key_data;
    logic [127:0] dp_state;
    logic [127:0] dp_key;
    logic         dp_first;
    logic [127:0] dp_result;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
    logic [3:0]   rnd;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [127:0] sched [16];

    aes_dec_round_ctrl #(.NR(10), .KAW(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .key_addr(key_addr), .key_data(key_data),
        .dp_state(dp_state), .dp_key(dp_key), .dp_first(dp_first), .dp_result(dp_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .rnd(rnd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- AES arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        d = d << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
        logic [127:0] o = '0;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = inv ? isbox[gb(s, i)] : sbox[gb(s, i)];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
        logic [127:0] o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(c*4+r) -: 8] = inv ? gb(s, ((c - r + 4) % 4) * 4 + r)
                                            : gb(s, ((c + r) % 4) * 4 + r);
        return o;
    endfunction

    function automatic logic [7:0] mc_coef(input bit inv, input int idx);
        case (idx)
            0:       return inv ? 8'h0e : 8'h02;
            1:       return inv ? 8'h0b : 8'h03;
            2:       return inv ? 8'h0d : 8'h01;
            default: return inv ? 8'h09 : 8'h01;
        endcase
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s, input bit inv);
        logic [127:0] o = '0;
        logic [7:0]   acc;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(mc_coef(inv, (j - r + 4) % 4), gb(s, c*4 + j));
                o[127-8*(c*4+r) -: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [127:0] s = pt ^ sched[0];
        for (int r = 1; r <= 10; r++) begin
            s = shift_rows(sub_bytes(s, 1'b0), 1'b0);
            if (r != 10) s = mix_cols(s, 1'b0);
            s = s ^ sched[r];
        end
        return s;
    endfunction

    function automatic logic [127:0] dp_model(input logic [127:0] s, input logic [127:0] k,
                                               input logic first);
        logic [127:0] t = s ^ k;
        if (!first) t = mix_cols(t, 1'b1);
        return sub_bytes(shift_rows(t, 1'b1), 1'b1);
    endfunction

    task automatic init_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox[x]  = s;
            isbox[s] = 8'(x);
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++)
            if (r <= 10) sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else         sched[r] = '0;
    endtask

    // External environment: combinational key store and inverse-round datapath
    assign key_data  = sched[key_addr];
    assign dp_result = dp_model(dp_state, dp_key, dp_first);

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called right after the accept edge; returns the cycle index of first out_valid, or -1
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        step(); step();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (key_addr !== 4'd0) begin n_fail++; $display("FAIL reset_key_addr got %0d want 0", key_addr); end
        n_checks++; if (rnd !== 4'd0) begin n_fail++; $display("FAIL reset_rnd got %0d want 0", rnd); end
        n_checks++; if (out_data !== 128'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
        n_checks++; if (dp_state !== 128'h0) begin n_fail++; $display("FAIL reset_state got %h want 0", dp_state); end
        n_checks++; if (dp_first !== 1'b0) begin n_fail++; $display("FAIL reset_dp_first got %b want 0", dp_first); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_fips();
        int lat;
        expand_key(128'h000102030405060708090a0b0c0d0e0f);
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fips_in_ready got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        wait_out(lat);
        n_checks++; if (lat !== 12) begin n_fail++; $display("FAIL fips_latency got %0d want 12", lat); end
        n_checks++; if (out_data !== 128'h00112233445566778899aabbccddeeff) begin
            n_fail++; $display("FAIL fips_plaintext got %h want 00112233445566778899aabbccddeeff", out_data); end
        step();
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL fips_return_idle got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    endtask

    task automatic test_key_seq();
        logic [127:0] pt;
        int lat;
        pt = rand128();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = encrypt(pt);
        step();
        in_valid = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            n_checks++; if (key_addr !== 4'(11 - c)) begin
                n_fail++; $display("FAIL keyseq_addr cycle %0d got %0d want %0d", c, key_addr, 11 - c); end
            n_checks++; if (dp_first !== (c == 1)) begin
                n_fail++; $display("FAIL keyseq_dp_first cycle %0d got %b want %b", c, dp_first, (c == 1)); end
            n_checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL keyseq_busy cycle %0d got busy=%b in_ready=%b want 1/0", c, busy, in_ready); end
            if (c < 11) step();
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL keyseq_early_valid got %b want 0", out_valid); end
        step();
        lat = out_valid ? 12 : -1;
        n_checks++; if (lat !== 12 || out_data !== pt) begin
            n_fail++; $display("FAIL keyseq_result got %h (valid cycle %0d) want %h at 12", out_data, lat, pt); end
        step();
    endtask

    task automatic test_backpressure();
        logic [127:0] pt;
        int lat;
        pt = rand128();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = encrypt(pt);
        step();
        in_valid = 1'b0;
        wait_out(lat);
        n_checks++; if (lat !== 12) begin n_fail++; $display("FAIL bp_latency got %0d want 12", lat); end
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (out_valid !== 1'b1 || out_data !== pt || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold cycle %0d got valid=%b data=%h in_ready=%b want 1/%h/0",
                                   k, out_valid, out_data, in_ready, pt); end
            step();
        end
        out_ready = 1'b1;
        n_checks++; if (out_valid !== 1'b1 || out_data !== pt) begin
            n_fail++; $display("FAIL bp_release got valid=%b data=%h want 1/%h", out_valid, out_data, pt); end
        step();
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL bp_idle got in_ready=%b valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy); end
    endtask

    task automatic test_busy_input();
        logic [127:0] pa;
        logic [127:0] pb;
        int lat;
        int c;
        pa = rand128(); pb = rand128();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = encrypt(pa);
        step();
        in_data = encrypt(pb);
        c = 1;
        while (!out_valid && c < 40) begin
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL busy_in_ready cycle %0d got %b want 0", c, in_ready); end
            step();
            c++;
        end
        lat = out_valid ? c : -1;
        n_checks++; if (lat !== 12) begin n_fail++; $display("FAIL busy_latency got %0d want 12", lat); end
        n_checks++; if (out_data !== pa) begin n_fail++; $display("FAIL busy_first_block got %h want %h", out_data, pa); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL busy_done_in_ready got %b want 0", in_ready); end
        step();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL busy_second_accept got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_second_started got %b want 1", busy); end
        wait_out(lat);
        n_checks++; if (lat !== 12 || out_data !== pb) begin
            n_fail++; $display("FAIL busy_second_block got %h at cycle %0d want %h at 12", out_data, lat, pb); end
        step();
    endtask

    task automatic test_reset_mid();
        logic [127:0] pt;
        int lat;
        bit seen;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = encrypt(rand128());
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) step();
        n_checks++; if (rnd !== 4'd5) begin n_fail++; $display("FAIL rstmid_rnd got %0d want 5", rnd); end
        rst = 1'b1; in_valid = 1'b1;
        step();
        n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_state got in_ready=%b busy=%b valid=%b want 1/0/0", in_ready, busy, out_valid); end
        n_checks++; if (key_addr !== 4'd0 || rnd !== 4'd0 || out_data !== 128'h0 || dp_first !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_regs got key_addr=%0d rnd=%0d data=%h first=%b want 0", key_addr, rnd, out_data, dp_first); end
        rst = 1'b0; in_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_output got %b want 0", seen); end
        pt = rand128();
        in_valid = 1'b1; in_data = encrypt(pt);
        step();
        in_valid = 1'b0;
        wait_out(lat);
        n_checks++; if (lat !== 12 || out_data !== pt) begin
            n_fail++; $display("FAIL rstmid_new_block got %h at cycle %0d want %h at 12", out_data, lat, pt); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [127:0] pts [4];
        logic [127:0] cts [4];
        int idx, nout, cyc, last;
        bit acc;
        expand_key(rand128());
        for (int i = 0; i < 4; i++) begin
            pts[i] = rand128();
            cts[i] = encrypt(pts[i]);
        end
        out_ready = 1'b1;
        idx = 0; nout = 0; cyc = 0; last = 0;
        in_valid = 1'b1; in_data = cts[0];
        for (int t = 0; t < 200 && nout < 4; t++) begin
            if (out_valid) begin
                n_checks++; if (out_data !== pts[nout]) begin
                    n_fail++; $display("FAIL b2b_data block %0d got %h want %h", nout, out_data, pts[nout]); end
                n_checks++; if (cyc - last !== ((nout == 0) ? 12 : 13)) begin
                    n_fail++; $display("FAIL b2b_spacing block %0d got %0d want %0d", nout, cyc - last, (nout == 0) ? 12 : 13); end
                last = cyc;
                nout++;
            end
            acc = in_valid && in_ready;
            step();
            cyc++;
            if (acc) begin
                idx++;
                if (idx < 4) in_data = cts[idx];
                else in_valid = 1'b0;
            end
        end
        n_checks++; if (nout !== 4) begin n_fail++; $display("FAIL b2b_count got %0d want 4", nout); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        for (int r = 0; r < 16; r++) sched[r] = '0;
        init_sbox();
        test_reset();
        test_fips();
        test_key_seq();
        test_backpressure();
        test_busy_input();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
